// File: rtl/counter_cmd_pkg.sv
// Shared types for the counter command sequencer: opcodes, FSM states,
// the queued command record and the step-count helper.
package counter_cmd_pkg;

   localparam int ARG_W = 8;

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_LOAD = 2'b01,
      OP_UP   = 2'b10,
      OP_DOWN = 2'b11
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN
   } seq_state_t;

   typedef struct packed {
      cmd_op_t          op;
      logic [ARG_W-1:0] arg;
   } cmd_t;

   // A repeat count of zero still does one cycle of work.
   function automatic logic [ARG_W-1:0] steps_of(input logic [ARG_W-1:0] n);
      return (n == '0) ? ARG_W'(1) : n;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO of cmd_t with full/empty flags and occupancy.
// Ports: clk, rst_ (async low), push/wr_data, pop/rd_data, full, empty, count.
module cmd_fifo
   import counter_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       push,
   input  cmd_t                       wr_data,
   input  logic                       pop,
   output cmd_t                       rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/counter_cmd_seq.sv
// Expands queued HOLD/LOAD/UP/DOWN commands into up/down counter controls.
// Ports: clk, rst_, cmd_valid/ready/op/arg in; ld_cnt_, updn_cnt,
// count_enb, data_in, busy, done out (all counter-facing outputs registered).
module counter_cmd_seq
   import counter_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic             ld_cnt_,
   output logic             updn_cnt,
   output logic             count_enb,
   output logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done
);

   cmd_t                       wr_cmd;
   cmd_t                       head;
   logic                       full;
   logic                       empty;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       take;
   logic                       last;
   logic [WIDTH-1:0]           steps;

   seq_state_t       state, state_n;
   logic [WIDTH-1:0] step, step_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic             ld_q, ld_n;
   logic             enb_q, enb_n;
   logic             updn_q, updn_n;
   logic             done_q, done_n;

   assign wr_cmd    = '{op: cmd_op_t'(cmd_op), arg: ARG_W'(cmd_arg)};
   assign cmd_ready = !full;

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_    (rst_),
      .push    (cmd_valid),
      .wr_data (wr_cmd),
      .pop     (take),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // The current cycle is the final action of its command; the next
   // command may be popped on the same edge so there is no bubble.
   assign last  = (state == ST_LOAD) ||
                  (state == ST_RUN && step == WIDTH'(1));
   assign take  = !empty && (state == ST_IDLE || last);
   assign steps = WIDTH'(steps_of(head.arg));

   always_comb begin
      state_n = state;
      step_n  = step;
      data_n  = data_q;
      ld_n    = 1'b1;
      enb_n   = enb_q;
      updn_n  = updn_q;
      done_n  = 1'b0;
      if (take) begin
         unique case (head.op)
            OP_LOAD: begin
               state_n = ST_LOAD;
               ld_n    = 1'b0;
               data_n  = WIDTH'(head.arg);
               enb_n   = 1'b0;
               done_n  = 1'b1;
            end
            OP_UP, OP_DOWN: begin
               state_n = ST_RUN;
               step_n  = steps;
               enb_n   = 1'b1;
               updn_n  = (head.op == OP_UP);
               done_n  = (steps == WIDTH'(1));
            end
            OP_HOLD: begin
               state_n = ST_RUN;
               step_n  = steps;
               enb_n   = 1'b0;
               done_n  = (steps == WIDTH'(1));
            end
         endcase
      end else if (last || state == ST_IDLE) begin
         state_n = ST_IDLE;
         enb_n   = 1'b0;
      end else begin
         step_n = step - 1'b1;
         done_n = (step == WIDTH'(2));
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state  <= ST_IDLE;
         step   <= '0;
         data_q <= '0;
         ld_q   <= 1'b1;
         enb_q  <= 1'b0;
         updn_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         step   <= step_n;
         data_q <= data_n;
         ld_q   <= ld_n;
         enb_q  <= enb_n;
         updn_q <= updn_n;
         done_q <= done_n;
      end
   end

   assign ld_cnt_   = ld_q;
   assign count_enb = enb_q;
   assign updn_cnt  = updn_q;
   assign data_in   = data_q;
   assign done      = done_q;
   assign busy      = (state != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq with a downstream 8-bit
// up/down counter and a per-command reference of its value.
module tb_counter_cmd_seq;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_arg = 8'h00;
   logic       ld_cnt_;
   logic       updn_cnt;
   logic       count_enb;
   logic [7:0] data_in;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] cnt;
   logic       mon_on = 1'b0;
   logic       pend = 1'b0;
   logic [7:0] pend_val = 8'h00;
   logic [7:0] expq [$];
   logic       rec_on = 1'b0;
   logic [7:0] loads [$];

   always #5 clk = ~clk;

   counter_cmd_seq #(.DEPTH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .ld_cnt_   (ld_cnt_),
      .updn_cnt  (updn_cnt),
      .count_enb (count_enb),
      .data_in   (data_in),
      .busy      (busy),
      .done      (done)
   );

   // downstream counter driven by the sequencer
   always @(posedge clk or negedge rst_) begin
      if (!rst_)            cnt <= 8'h00;
      else if (!ld_cnt_)    cnt <= data_in;
      else if (count_enb)   cnt <= updn_cnt ? cnt + 8'd1 : cnt - 8'd1;
   end

   // after each done, the counter must hold the command's final value
   always @(negedge clk) begin
      if (mon_on) begin
         n_tests++;
         if (!ld_cnt_ && count_enb) begin
            n_fail++;
            $display("FAIL ld_enb_excl: both active at %0t", $time);
         end
         if (pend) begin
            n_tests++;
            if (cnt !== pend_val) begin
               n_fail++;
               $display("FAIL cnt_value: got %h want %h at %0t",
                        cnt, pend_val, $time);
            end
            pend = 1'b0;
         end
         if (done) begin
            if (expq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_done: got done=1 want none at %0t", $time);
            end else begin
               pend     = 1'b1;
               pend_val = expq.pop_front();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rec_on && !ld_cnt_) loads.push_back(data_in);
   end

   function automatic logic [7:0] apply_cmd(input logic [7:0] v,
                                            input logic [1:0] op,
                                            input logic [7:0] a);
      int n;
      n = (a == 8'd0) ? 1 : int'(a);
      case (op)
         2'b01:   return a;
         2'b10:   return 8'(int'(v) + n);
         2'b11:   return 8'(int'(v) - n);
         default: return v;
      endcase
   endfunction

   // called at a negedge; returns at the negedge after the accept edge
   task automatic push(input logic [1:0] op, input logic [7:0] arg,
                       output int waited, output logic ok);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      waited    = 0;
      while (!cmd_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      ok = cmd_ready;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: got ready=0 want 1 after %0d cycles", waited);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst_ = 1'b0;
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({ld_cnt_, count_enb, updn_cnt, done, busy, data_in} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_outs: got %b%b%b%b%b %h want 10000 00",
                  ld_cnt_, count_enb, updn_cnt, done, busy, data_in);
      end
      rst_ = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_ready: got ready=%b busy=%b want 1 0",
                  cmd_ready, busy);
      end
   endtask

   task automatic test_load();
      int w;
      logic ok;
      push(2'b01, 8'h5A, w, ok);
      @(negedge clk);
      n_tests++;
      if ({ld_cnt_, count_enb, done, data_in} !== {1'b0, 1'b0, 1'b1, 8'h5A}) begin
         n_fail++;
         $display("FAIL load_cycle: got ld=%b enb=%b done=%b data=%h want 0 0 1 5a",
                  ld_cnt_, count_enb, done, data_in);
      end
      @(negedge clk);
      n_tests++;
      if ({ld_cnt_, count_enb, done, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL load_after: got %b%b%b%b want 1000",
                  ld_cnt_, count_enb, done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int   w;
      logic ok;
      bit   eu [5] = '{1, 1, 1, 0, 0};
      bit   ed [5] = '{0, 0, 1, 0, 1};
      push(2'b10, 8'd3, w, ok);
      push(2'b11, 8'd2, w, ok);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         n_tests++;
         if ({count_enb, ld_cnt_, updn_cnt, done} !==
             {1'b1, 1'b1, eu[k], ed[k]}) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: got enb=%b ld=%b up=%b done=%b want 1 1 %b %b",
                     k, count_enb, ld_cnt_, updn_cnt, done, eu[k], ed[k]);
         end
      end
      @(negedge clk);
      n_tests++;
      if ({count_enb, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_end: got enb=%b busy=%b want 0 0", count_enb, busy);
      end
   endtask

   task automatic test_hold_zero();
      int w;
      logic ok;
      push(2'b00, 8'd0, w, ok);
      @(negedge clk);
      n_tests++;
      if ({count_enb, ld_cnt_, done, busy} !== 4'b0111) begin
         n_fail++;
         $display("FAIL hold0_cycle: got %b%b%b%b want 0111",
                  count_enb, ld_cnt_, done, busy);
      end
      @(negedge clk);
      n_tests++;
      if ({done, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL hold0_after: got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_full();
      int         w;
      int         k;
      logic       ok;
      logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      loads.delete();
      rec_on = 1'b1;
      push(2'b10, 8'd20, w, ok);
      for (int i = 0; i < 4; i++) push(2'b01, vals[i], w, ok);
      n_tests++;
      if (cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready: got %b want 0", cmd_ready);
      end
      push(2'b01, vals[4], w, ok);
      n_tests++;
      if (w != 17) begin
         n_fail++;
         $display("FAIL full_wait: got %0d cycles want 17", w);
      end
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      rec_on = 1'b0;
      n_tests++;
      if (loads.size() != 5) begin
         n_fail++;
         $display("FAIL full_loads: got %0d loads want 5", loads.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (loads[i] !== vals[i]) begin
               n_fail++;
               $display("FAIL full_order%0d: got %h want %h", i, loads[i], vals[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int w;
      logic ok;
      push(2'b10, 8'd10, w, ok);
      push(2'b01, 8'h66, w, ok);
      push(2'b01, 8'h77, w, ok);
      n_tests++;
      if (count_enb !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_running: got enb=%b want 1", count_enb);
      end
      #2 rst_ = 1'b0;
      #1;
      n_tests++;
      if ({count_enb, ld_cnt_, done, busy, cmd_ready} !== 5'b01001) begin
         n_fail++;
         $display("FAIL mid_abort: got %b%b%b%b%b want 01001",
                  count_enb, ld_cnt_, done, busy, cmd_ready);
      end
      @(negedge clk);
      rst_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++;
         if ({count_enb, ld_cnt_, done, busy, cmd_ready} !== 5'b01001) begin
            n_fail++;
            $display("FAIL mid_after%0d: got %b%b%b%b%b want 01001",
                     i, count_enb, ld_cnt_, done, busy, cmd_ready);
         end
      end
   endtask

   task automatic test_random();
      int         w;
      int         k;
      logic       ok;
      logic [7:0] mv;
      logic [1:0] op;
      logic [7:0] a;
      logic [1:0] fop [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
      logic [7:0] farg [4] = '{8'hFE, 8'd3, 8'd4, 8'd2};
      do_reset();
      mv = 8'h00;
      expq.delete();
      pend = 1'b0;
      mon_on = 1'b1;
      for (int i = 0; i < 204; i++) begin
         if (i < 4) begin
            op = fop[i];
            a  = farg[i];
         end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = 2'($urandom_range(0, 3));
            if (op == 2'b01) begin
               case ($urandom_range(0, 3))
                  0:       a = 8'hFF;
                  1:       a = 8'h00;
                  2:       a = 8'hFE;
                  default: a = 8'($urandom);
               endcase
            end else if ($urandom_range(0, 19) == 0) begin
               a = 8'($urandom_range(200, 255));
            end else begin
               a = 8'($urandom_range(0, 5));
            end
         end
         push(op, a, w, ok);
         if (ok) begin
            mv = apply_cmd(mv, op, a);
            expq.push_back(mv);
         end
      end
      k = 0;
      while ((busy || pend) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      mon_on = 1'b0;
      n_tests++;
      if (busy || expq.size() != 0 || cnt !== mv) begin
         n_fail++;
         $display("FAIL rand_end: got busy=%b left=%0d cnt=%h want 0 0 %h",
                  busy, expq.size(), cnt, mv);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_hold_zero();
      test_full();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
